// File: rtl/regfile_rsp.sv
// Two-read/one-write register file with zero-latency bypass and a post-reset
// clear sweep (single write port, so entries are zeroed one per cycle).
module regfile_rsp #(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic              busy,
    output logic              wr_drop
);

    typedef enum logic {INIT, READY} state_e;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              wr_drop_q, wr_drop_d;
    logic [DATA_W-1:0] mem_q [NUM_REGS];

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wr_drop_d = 1'b0;
        if (state_q == INIT) begin
            idx_d     = idx_q + ADDR_W'(1);
            wr_drop_d = we;
            if (idx_q == LAST_IDX) state_d = READY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= INIT;
            idx_q     <= ADDR_W'(1);
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    // Entry 0 is never written or read; the read mux forces it to zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == INIT)
                mem_q[idx_q] <= '0;
            else if (we && waddr != '0)
                mem_q[waddr] <= wdata;
        end
    end

    function automatic logic [DATA_W-1:0] rd_port(input logic en, input logic [ADDR_W-1:0] a);
        if (rst || !en || a == '0 || state_q == INIT) return '0;
        if (we && waddr == a) return wdata;
        return mem_q[a];
    endfunction

    always_comb begin
        rdata1 = rd_port(re1, raddr1);
        rdata2 = rd_port(re2, raddr2);
    end

    assign busy    = rst | (state_q == INIT);
    assign wr_drop = wr_drop_q;

endmodule

// File: tb/tb_regfile_rsp.sv
// Directed bench for regfile_rsp: architectural model checked every cycle,
// plus hand-computed literal checks at the scenario boundaries.
module tb_regfile_rsp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic        re1 = 1'b0;
    logic [4:0]  raddr1 = '0;
    logic [31:0] rdata1;
    logic        re2 = 1'b0;
    logic [4:0]  raddr2 = '0;
    logic [31:0] rdata2;
    logic        busy;
    logic        wr_drop;

    regfile_rsp dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
        .busy(busy), .wr_drop(wr_drop)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Architectural model: registers read as zero until 31 clean edges
    // have passed since the last reset; afterwards it is a plain array.
    logic [31:0] m_reg [32];
    int          m_cnt  = 0;
    bit          m_drop = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_cnt  = 0;
            m_drop = 1'b0;
            for (int i = 0; i < 32; i++) m_reg[i] = '0;
        end else if (m_cnt < 31) begin
            m_cnt++;
            m_drop = we;
        end else begin
            m_drop = 1'b0;
            if (we && waddr != 0) m_reg[waddr] = wdata;
        end
    end

    function automatic logic [31:0] m_rd(input logic en, input logic [4:0] a);
        if (rst || !en || a == 0 || m_cnt < 31) return '0;
        if (we && waddr == a) return wdata;
        return m_reg[a];
    endfunction

    always @(negedge clk) begin
        chk("model_rdata1", rdata1, m_rd(re1, raddr1));
        chk("model_rdata2", rdata2, m_rd(re2, raddr2));
        chk("model_busy", 32'(busy), 32'(rst || m_cnt < 31));
        chk("model_wr_drop", 32'(wr_drop), 32'(m_drop));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Inputs change 1 after the edge; literal checks sample 3 later.
    task automatic settle();
        #3;
    endtask

    initial begin
        re1 = 1'b1; raddr1 = 5'd5;
        repeat (3) cyc();
        settle();
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_rdata1", rdata1, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 31; i++) begin
            we = (i == 10); waddr = 5'd4; wdata = 32'hAA;
            settle();
            chk("sweep_busy", 32'(busy), 32'd1);
            chk("sweep_rdata1", rdata1, 32'd0);
            cyc();
            if (i == 10) begin
                settle();
                chk("init_drop", 32'(wr_drop), 32'd1);
            end
        end
        we = 1'b0;
        settle();
        chk("ready_busy", 32'(busy), 32'd0);
        chk("ready_drop", 32'(wr_drop), 32'd0);
        raddr1 = 5'd4;
        settle();
        chk("reg4_dropped", rdata1, 32'd0);
        cyc();

        we = 1'b1; waddr = 5'd3; wdata = 32'hDEADBEEF;
        cyc();
        we = 1'b0; re1 = 1'b1; raddr1 = 5'd3;
        settle();
        chk("reg3_read", rdata1, 32'hDEADBEEF);
        re1 = 1'b0;
        settle();
        chk("reg3_re_off", rdata1, 32'd0);
        cyc();

        we = 1'b1; waddr = 5'd7; wdata = 32'h12345678;
        re1 = 1'b1; re2 = 1'b1; raddr1 = 5'd7; raddr2 = 5'd7;
        settle();
        chk("byp_p1", rdata1, 32'h12345678);
        chk("byp_p2", rdata2, 32'h12345678);
        cyc();
        we = 1'b0;
        settle();
        chk("byp_held_p1", rdata1, 32'h12345678);
        chk("byp_held_p2", rdata2, 32'h12345678);
        cyc();

        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; raddr1 = 5'd0;
        settle();
        chk("r0_bypass", rdata1, 32'd0);
        cyc();
        we = 1'b0;
        settle();
        chk("r0_read", rdata1, 32'd0);
        chk("r0_no_drop", 32'(wr_drop), 32'd0);

        // Independent ports on different registers, bypass on one only.
        we = 1'b1; waddr = 5'd3; wdata = 32'hCAFEF00D; raddr1 = 5'd3; raddr2 = 5'd7;
        settle();
        chk("mix_p1", rdata1, 32'hCAFEF00D);
        chk("mix_p2", rdata2, 32'h12345678);
        cyc();

        waddr = 5'd9; wdata = 32'h11;
        cyc();
        wdata = 32'h55;
        cyc();
        we = 1'b0; raddr1 = 5'd9; raddr2 = 5'd31;
        settle();
        chk("reg9_last_wins", rdata1, 32'h55);
        chk("reg31_zero", rdata2, 32'd0);
        for (int i = 1; i < 32; i += 5) begin
            we = 1'b1; waddr = 5'(i); wdata = 32'h0100_0000 * 32'(i) + 32'(i);
            raddr2 = 5'(i);
            cyc();
        end
        we = 1'b0;
        cyc();

        rst = 1'b1; we = 1'b1; waddr = 5'd9; wdata = 32'h77;
        settle();
        chk("midrst_rdata1", rdata1, 32'd0);
        chk("midrst_busy", 32'(busy), 32'd1);
        cyc();
        rst = 1'b0; we = 1'b0;
        settle();
        chk("midrst_no_drop", 32'(wr_drop), 32'd0);
        for (int i = 0; i < 31; i++) begin
            settle();
            chk("resweep_busy", 32'(busy), 32'd1);
            cyc();
        end
        settle();
        chk("resweep_done", 32'(busy), 32'd0);
        chk("reg9_cleared", rdata1, 32'd0);
        cyc();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
